pipe_div_unit: RTL and testbench
================================

# pipe_div_unit

Multicycle iterative divider serving the EXE stage's `div` request. EXE issues `start` with operands and a sign flag. The unit runs a 32-step restoring division, then returns quotient `q`, remainder `r`, an iteration `counter` and a one-cycle `done` pulse. Hazard logic holds the pipeline on `busy`, and the hi/lo write path consumes `q` (lo) and `r` (hi).

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when the unit is idle.
- sign  in  1  1 = signed (div), 0 = unsigned (divu).
- a  in  32  dividend.
- b  in  32  divisor.
- q  out  32  quotient; registered, held until the next accepted start.
- r  out  32  remainder; registered, held until the next accepted start.
- counter  out  32  iterations completed in the current or last op (0..32); upper bits are zero.
- busy  out  1  high while an op is in progress.
- done  out  1  one-cycle pulse when `q`/`r` become valid.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1 → RUN:
  - Latch |a| and |b|: two's-complement magnitude when sign=1 and the MSB is set, otherwise the raw value.
  - Latch neg_q = sign & (a[31]^b[31]), neg_r = sign & a[31], and div0 = (b==0).
  - Clear the partial remainder and counter.
- IDLE, start=0: hold everything; outputs unchanged.
- RUN: each cycle, shift {rem, dvd} left by 1 and trial-subtract |b| from rem.
  - No borrow: keep the difference and set quotient bit 1.
  - Borrow: restore and set quotient bit 0.
  - Increment counter; after the 32nd iteration (counter=32) → FIX.
- FIX → IDLE, loading the outputs:
  - q = neg_q ? −quot : quot; r = neg_r ? −rem : rem.
  - If div0: q = 32'hFFFF_FFFF and r = a as originally latched, regardless of sign.
  - Pulse done.
- `start` while busy is ignored; operands are not re-latched.
- Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF → q = 32'h8000_0000, r = 0. This falls out of the magnitude algorithm and needs no special case.
- Remainder sign follows the dividend and |r| < |b| (MIPS semantics).

## Timing
- Reset (asynchronous, any state): state=IDLE; q, r, counter = 0; busy=0; done=0. An op in flight is abandoned and no done pulse is produced.
- Edge E0: start accepted. busy=1 and counter=0 from E0.
- Edges E1..E32: iterations; counter reads k after Ek.
- Edge E33: FIX completes. q/r valid, done=1, busy=0 for exactly one cycle.
- Edge E34: done=0.
- Total: busy high for 33 cycles, result latency 33 cycles from acceptance.
- Back-to-back: start asserted during the done cycle is accepted at E34. q/r hold their old values until the new FIX.
- Latency is fixed at 33 cycles, including divide-by-zero.

## Structure
- Package `pipe_div_pkg`:
  - state enum {IDLE, RUN, FIX}.
  - ITER = 32.
  - DIV0_Q = 32'hFFFF_FFFF.
- Sub-module: the existing `cla32` with sub=1 for the 33-bit trial subtraction. A second `cla32` instance is not needed: magnitude and sign fix-up share one negate helper function in the package.
- One always block for state/datapath registers; combinational next-state logic.

## Test plan
- Unsigned: a=7, b=2, sign=0 → done after 33 cycles; q=3, r=1, counter=32.
- Signed: a=−7 (32'hFFFF_FFF9), b=2, sign=1 → q=32'hFFFF_FFFD, r=32'hFFFF_FFFF.
- Overflow: a=32'h8000_0000, b=32'hFFFF_FFFF, sign=1 → q=32'h8000_0000, r=0. Same operands with sign=0 → q=0, r=32'h8000_0000.
- Divide by zero: a=32'h1234_5678, b=0, sign=1 → q=32'hFFFF_FFFF, r=32'h1234_5678; done at cycle 33.
- Start while busy: new operands pulsed at cycle 10 → ignored. Result matches the first op and done pulses exactly once.
- Reset mid-op: resetn low at cycle 15 → busy=0, q=r=counter=0 immediately, no done pulse. A fresh op afterwards completes correctly.

Source files
------------

// File: rtl/pipe_div_pkg.sv
// Shared types, constants and the two's-complement negate helper for the
// iterative divider.
package pipe_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX} div_state_e;

  localparam int          ITER   = 32;
  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of a possibly-signed operand; unsigned values pass through.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder/subtractor built from 4-bit lookahead groups.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] bx;
  logic [31:0] g;
  logic [31:0] p;

  assign bx = b ^ {32{sub}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  // Group generate/propagate decide the carry into the next nibble directly.
  always_comb begin
    logic c_grp;
    logic c_bit;
    logic grp_g;
    logic grp_p;
    sum   = '0;
    c_grp = sub;
    for (int k = 0; k < 8; k++) begin
      c_bit = c_grp;
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < 4; i++) begin
        sum[4*k+i] = p[4*k+i] ^ c_bit;
        c_bit      = g[4*k+i] | (p[4*k+i] & c_bit);
        grp_g      = g[4*k+i] | (p[4*k+i] & grp_g);
        grp_p      = grp_p & p[4*k+i];
      end
      c_grp = grp_g | (grp_p & c_grp);
    end
    cout = c_grp;
  end

endmodule

// File: rtl/pipe_div_unit.sv
// 32-step restoring divider for div/divu: magnitude division followed by a
// one-cycle sign fix-up, fixed 33-cycle latency including divide-by-zero.
module pipe_div_unit
  import pipe_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             done
);

  div_state_e  state, state_nxt;
  logic [31:0] rem;
  logic [31:0] dvd;
  logic [31:0] bmag;
  logic [31:0] a_lat;
  logic        neg_q;
  logic        neg_r;
  logic        div0;
  logic [5:0]  cnt;

  logic [32:0] rem_sh;
  logic [31:0] diff;
  logic        cout;
  logic        no_borrow;

  // rem_sh[32] set means the shifted remainder already exceeds any 32-bit divisor.
  assign rem_sh    = {rem, dvd[31]};
  assign no_borrow = rem_sh[32] | cout;

  cla32 u_trial_sub (
    .a    (rem_sh[31:0]),
    .b    (bmag),
    .sub  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  assign busy    = (state != IDLE);
  assign counter = {26'd0, cnt};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 6'(ITER - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      rem   <= '0;
      dvd   <= '0;
      bmag  <= '0;
      a_lat <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_lat <= a;
          dvd   <= mag32(a, sign);
          bmag  <= mag32(b, sign);
          neg_q <= sign & (a[31] ^ b[31]);
          neg_r <= sign & a[31];
          div0  <= (b == '0);
          rem   <= '0;
          cnt   <= '0;
        end
        RUN: begin
          rem <= no_borrow ? diff : rem_sh[31:0];
          dvd <= {dvd[30:0], no_borrow};
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          q    <= div0 ? DIV0_Q : (neg_q ? neg32(dvd) : dvd);
          r    <= div0 ? a_lat  : (neg_r ? neg32(rem) : rem);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_div_unit.sv
// Directed-vector bench for pipe_div_unit with hand-computed results.
module tb_pipe_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] counter;
  logic        busy;
  logic        done;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  always #5 clk = ~clk;

  pipe_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .sign    (sign),
    .a       (a),
    .b       (b),
    .q       (q),
    .r       (r),
    .counter (counter),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one op at the current negedge and returns at the negedge where done is seen.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input logic [31:0] eq, input logic [31:0] er,
                        input int pulse_at);
    int n;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    sign  = ts;
    @(negedge clk);
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_0003;
    sign  = ~ts;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    chk({tag, "_cnt_e0"}, counter, 32'd0);
    n = 0;
    while (!done && n < 100) begin
      if (pulse_at > 0 && n == pulse_at) begin
        start = 1'b1;
        a     = 32'h0000_0005;
        b     = 32'h0000_0001;
      end
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 5) chk({tag, "_cnt_mid"}, counter, 32'd5);
      if (n == 16) begin
        chk({tag, "_q_hold"}, q, last_q);
        chk({tag, "_r_hold"}, r, last_r);
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'd33);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_cnt_end"}, counter, 32'd32);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    last_q = eq;
    last_r = er;
  endtask

  task automatic quiet(input string tag, input int k);
    int d;
    d = 0;
    repeat (k) begin
      @(negedge clk);
      if (done) d++;
    end
    chk({tag, "_extra_done"}, 32'(d), 32'd0);
    chk({tag, "_q_keep"}, q, last_q);
  endtask

  initial begin
    int d;
    resetn = 1'b0;
    start  = 1'b0;
    sign   = 1'b0;
    a      = '0;
    b      = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_cnt", counter, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run_op("udiv", 32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 0);
    quiet("udiv", 3);
    run_op("sdiv", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    quiet("sdiv", 2);
    run_op("ovf_s", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 0);
    quiet("ovf_s", 2);
    run_op("ovf_u", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 0);
    quiet("ovf_u", 2);
    run_op("div0", 32'h1234_5678, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 0);
    quiet("div0", 2);
    run_op("busy_start", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 10);
    quiet("busy_start", 5);

    // Second op issued in the done cycle of the first.
    run_op("b2b_a", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 0);
    run_op("b2b_b", 32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 0);
    quiet("b2b", 2);

    start = 1'b1;
    a     = 32'd1000;
    b     = 32'd3;
    sign  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_q", q, 32'd0);
    chk("mid_rst_r", r, 32'd0);
    chk("mid_rst_cnt", counter, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    d = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) d++;
    end
    chk("mid_rst_no_done", 32'(d), 32'd0);
    last_q = '0;
    last_r = '0;
    run_op("after_rst", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 0);
    quiet("after_rst", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
